// File: rtl/branch_predictor_pl.sv
// branch_predictor_pl
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Looked up combinationally with the IF-stage PC, trained from the EX stage.
// Flags mispredictions, supplies the redirect PC, offers a whole-table
// invalidate sweep and keeps saturating branch / mispredict statistics.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   F_pc                IF-stage PC
//   F_pred_taken        prediction for F_pc is taken
//   F_pred_target       predicted target (entry target on hit, else 0)
//   F_next_pc           F_pred_taken ? F_pred_target : F_pc+4
//   E_valid .. E_pred_target   resolved EX-stage instruction information
//   E_mispredict        flush request for IF/ID and ID/EX
//   E_redirect_pc       correct next PC when E_mispredict=1
//   inv_req             single-cycle request to invalidate the whole BTB
//   busy                invalidate sweep in progress
//   cnt_branches        resolved branches and jumps (saturating)
//   cnt_mispredicts     mispredictions (saturating)
module branch_predictor_pl #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    F_pc,
   output logic               F_pred_taken,
   output logic [XLEN-1:0]    F_pred_target,
   output logic [XLEN-1:0]    F_next_pc,
   input  logic               E_valid,
   input  logic [XLEN-1:0]    E_pc,
   input  logic               E_branch,
   input  logic               E_jump,
   input  logic               E_taken,
   input  logic [XLEN-1:0]    E_target,
   input  logic               E_pred_taken,
   input  logic [XLEN-1:0]    E_pred_target,
   output logic               E_mispredict,
   output logic [XLEN-1:0]    E_redirect_pc,
   input  logic               inv_req,
   output logic               busy,
   output logic [COUNT_W-1:0] cnt_branches,
   output logic [COUNT_W-1:0] cnt_mispredicts
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [XLEN-1:0]    PC_STEP  = XLEN'(4);
   localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(ENTRIES - 1);
   localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   state_t             state;
   logic [IDX_W-1:0]   sweep_idx;
   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem    [ENTRIES];
   logic [XLEN-1:0]    target_mem [ENTRIES];
   logic [1:0]         ctr_mem    [ENTRIES];
   logic [ENTRIES-1:0] jump_mem;

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic [IDX_W-1:0] e_idx;
   logic [TAG_W-1:0] e_tag;
   logic             e_hit;
   logic             actual;
   logic             is_ctrl;
   logic             do_update;
   logic             write_entry;
   logic             do_stale;
   logic [1:0]       ctr_next;

   // Saturating 2-bit direction counter step.
   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
      logic [1:0] res;
      if (up) begin
         res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return res;
   endfunction

   assign busy  = (state == SWEEP);
   assign f_idx = F_pc[IDX_W+1:2];
   assign f_tag = F_pc[XLEN-1:IDX_W+2];
   assign e_idx = E_pc[IDX_W+1:2];
   assign e_tag = E_pc[XLEN-1:IDX_W+2];

   // IF-stage lookup; every lookup misses while the sweep runs.
   always_comb begin
      f_hit = valid[f_idx] && (tag_mem[f_idx] == f_tag) && !busy;
      if (f_hit) begin
         F_pred_taken  = jump_mem[f_idx] | ctr_mem[f_idx][1];
         F_pred_target = target_mem[f_idx];
      end else begin
         F_pred_taken  = 1'b0;
         F_pred_target = '0;
      end
      F_next_pc = F_pred_taken ? F_pred_target : F_pc + PC_STEP;
   end

   // EX-stage resolution and update decode.
   always_comb begin
      actual        = E_jump | (E_branch & E_taken);
      is_ctrl       = E_branch | E_jump;
      e_hit         = valid[e_idx] && (tag_mem[e_idx] == e_tag);
      // A non-control instruction predicted taken falls out of the first term.
      E_mispredict  = E_valid & ((actual != E_pred_taken) |
                                 (actual & E_pred_taken & (E_pred_target != E_target)));
      E_redirect_pc = actual ? E_target : E_pc + PC_STEP;
      do_update     = E_valid & !busy & is_ctrl;
      // Hits always rewrite; misses only allocate when the transfer happened.
      write_entry   = do_update & (e_hit | actual);
      do_stale      = E_valid & !busy & !is_ctrl & e_hit;
      if (e_hit) begin
         ctr_next = sat_ctr(ctr_mem[e_idx], actual);
      end else begin
         ctr_next = 2'b10;
      end
   end

   // Entry payload; meaningless while the matching valid bit is clear.
   always_ff @(posedge clk) begin
      if (write_entry) begin
         tag_mem[e_idx]    <= e_tag;
         target_mem[e_idx] <= E_target;
         ctr_mem[e_idx]    <= ctr_next;
         jump_mem[e_idx]   <= E_jump;
      end
   end

   // Valid bits and invalidate-sweep FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sweep_idx <= '0;
         valid     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_entry) begin
                  valid[e_idx] <= 1'b1;
               end else if (do_stale) begin
                  valid[e_idx] <= 1'b0;
               end
               if (inv_req) begin
                  state     <= SWEEP;
                  sweep_idx <= '0;
               end
            end
            SWEEP: begin
               valid[sweep_idx] <= 1'b0;
               sweep_idx        <= sweep_idx + IDX_ONE;
               if (sweep_idx == IDX_LAST) begin
                  state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               sweep_idx <= '0;
            end
         endcase
      end
   end

   // Saturating statistics; they keep counting during a sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_branches    <= '0;
         cnt_mispredicts <= '0;
      end else begin
         if (E_valid && is_ctrl && (cnt_branches != '1)) begin
            cnt_branches <= cnt_branches + CNT_ONE;
         end
         if (E_mispredict && (cnt_mispredicts != '1)) begin
            cnt_mispredicts <= cnt_mispredicts + CNT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor_pl.sv
// tb_branch_predictor_pl
// Directed bench for branch_predictor_pl (XLEN=32, ENTRIES=16, COUNT_W=4).
// Expected values are hand-computed; counter expectations come from a small
// saturating model stepped by each resolved vector.
module tb_branch_predictor_pl;
   logic        clk;
   logic        rst;
   logic [31:0] F_pc;
   logic        F_pred_taken;
   logic [31:0] F_pred_target;
   logic [31:0] F_next_pc;
   logic        E_valid;
   logic [31:0] E_pc;
   logic        E_branch;
   logic        E_jump;
   logic        E_taken;
   logic [31:0] E_target;
   logic        E_pred_taken;
   logic [31:0] E_pred_target;
   logic        E_mispredict;
   logic [31:0] E_redirect_pc;
   logic        inv_req;
   logic        busy;
   logic [3:0]  cnt_branches;
   logic [3:0]  cnt_mispredicts;

   int checks   = 0;
   int failures = 0;
   int exp_b    = 0;
   int exp_m    = 0;
   int n;

   branch_predictor_pl #(.XLEN(32), .ENTRIES(16), .COUNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .F_pc(F_pc), .F_pred_taken(F_pred_taken), .F_pred_target(F_pred_target),
      .F_next_pc(F_next_pc),
      .E_valid(E_valid), .E_pc(E_pc), .E_branch(E_branch), .E_jump(E_jump),
      .E_taken(E_taken), .E_target(E_target), .E_pred_taken(E_pred_taken),
      .E_pred_target(E_pred_target), .E_mispredict(E_mispredict),
      .E_redirect_pc(E_redirect_pc),
      .inv_req(inv_req), .busy(busy),
      .cnt_branches(cnt_branches), .cnt_mispredicts(cnt_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic e_idle();
      E_valid = 1'b0; E_pc = 32'h0; E_branch = 1'b0; E_jump = 1'b0; E_taken = 1'b0;
      E_target = 32'h0; E_pred_taken = 1'b0; E_pred_target = 32'h0;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_tk,
                         input logic [31:0] exp_tgt, input logic [31:0] exp_next);
      F_pc = pc;
      #1;
      check_val({tag, "_tk"}, {31'h0, F_pred_taken}, {31'h0, exp_tk});
      check_val({tag, "_tgt"}, F_pred_target, exp_tgt);
      check_val({tag, "_next"}, F_next_pc, exp_next);
   endtask

   // Apply one EX vector, check the combinational flags, clock it in and
   // check the statistics against the saturating model.
   task automatic resolve(input string tag, input logic br, input logic jp, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptg,
                          input logic exp_mis, input logic [31:0] exp_red);
      E_valid = 1'b1; E_branch = br; E_jump = jp; E_taken = tk; E_pc = pc;
      E_target = tgt; E_pred_taken = pt; E_pred_target = ptg;
      #1;
      check_val({tag, "_mis"}, {31'h0, E_mispredict}, {31'h0, exp_mis});
      check_val({tag, "_red"}, E_redirect_pc, exp_red);
      if (br || jp) exp_b = (exp_b == 15) ? 15 : exp_b + 1;
      if (exp_mis) exp_m = (exp_m == 15) ? 15 : exp_m + 1;
      step();
      e_idle();
      check_val({tag, "_cb"}, {28'h0, cnt_branches}, exp_b);
      check_val({tag, "_cm"}, {28'h0, cnt_mispredicts}, exp_m);
   endtask

   initial begin
      rst = 1'b1; inv_req = 1'b0; F_pc = 32'h100;
      e_idle();
      step();
      step();
      rst = 1'b0;
      #1;
      check_val("rst_busy", {31'h0, busy}, 32'h0);
      check_val("rst_cb", {28'h0, cnt_branches}, 32'h0);
      check_val("rst_cm", {28'h0, cnt_mispredicts}, 32'h0);
      lookup("rst_look", 32'h100, 1'b0, 32'h0, 32'h104);

      // First taken branch: mispredicted, then allocated with ctr=2.
      F_pc = 32'h100;
      E_valid = 1'b1; E_branch = 1'b1; E_taken = 1'b1; E_pc = 32'h100; E_target = 32'h80;
      #1;
      check_val("same_cycle_old", {31'h0, F_pred_taken}, 32'h0);
      resolve("br1", 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
      lookup("br1_look", 32'h100, 1'b1, 32'h80, 32'h80);

      // Two not-taken: ctr 2->1->0, entry stays valid (target still reported).
      resolve("nt1", 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
      lookup("nt1_look", 32'h100, 1'b0, 32'h80, 32'h104);
      resolve("nt2", 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0, 32'h104);
      lookup("nt2_look", 32'h100, 1'b0, 32'h80, 32'h104);

      // Three taken saturate at 3; one not-taken still predicts taken.
      for (int i = 0; i < 3; i++)
         resolve("tk", 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
      resolve("sat_nt", 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
      lookup("sat_look", 32'h100, 1'b1, 32'h80, 32'h80);

      // jal at 0x200 -> 0x400.
      resolve("jal", 1'b0, 1'b1, 1'b0, 32'h200, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
      lookup("jal_look", 32'h200, 1'b1, 32'h400, 32'h400);
      resolve("jal_ok", 1'b0, 1'b1, 1'b0, 32'h200, 32'h400, 1'b1, 32'h400, 1'b0, 32'h400);
      resolve("jal_badtgt", 1'b0, 1'b1, 1'b0, 32'h200, 32'h400, 1'b1, 32'h404, 1'b1, 32'h400);

      // PC+4 wraps at the top of the address space.
      resolve("wrap", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      lookup("wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);

      // Non-control instruction predicted taken: mispredict and stale invalidate.
      resolve("stale", 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 32'h400, 1'b1, 32'h204);
      lookup("stale_look", 32'h200, 1'b0, 32'h0, 32'h204);

      // Aliasing: 0x140 shares index 0 with 0x100 and replaces it.
      resolve("alias", 1'b1, 1'b0, 1'b1, 32'h140, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
      lookup("alias_new", 32'h140, 1'b1, 32'h300, 32'h300);
      lookup("alias_old", 32'h100, 1'b0, 32'h0, 32'h104);

      // Fill three more entries (4 valid), then sweep.
      resolve("fill1", 1'b1, 1'b0, 1'b1, 32'h104, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
      resolve("fill2", 1'b1, 1'b0, 1'b1, 32'h108, 32'h504, 1'b0, 32'h0, 1'b1, 32'h504);
      resolve("fill3", 1'b1, 1'b0, 1'b1, 32'h10C, 32'h508, 1'b0, 32'h0, 1'b1, 32'h508);
      lookup("fill_look", 32'h108, 1'b1, 32'h504, 32'h504);

      inv_req = 1'b1;
      step();
      inv_req = 1'b0;
      check_val("sweep_start", {31'h0, busy}, 32'h1);
      n = 0;
      while (busy && n < 40) begin
         if (n == 1) lookup("sweep_miss", 32'h104, 1'b0, 32'h0, 32'h108);
         if (n == 2) begin
            E_valid = 1'b1; E_branch = 1'b1; E_taken = 1'b1; E_pc = 32'h110;
            E_target = 32'h310; E_pred_taken = 1'b0;
            exp_b = (exp_b == 15) ? 15 : exp_b + 1;
            exp_m = (exp_m == 15) ? 15 : exp_m + 1;
         end
         if (n == 5) inv_req = 1'b1;
         n++;
         step();
         e_idle();
         inv_req = 1'b0;
      end
      check_val("sweep_len", n, 32'd16);
      check_val("sweep_cb", {28'h0, cnt_branches}, exp_b);
      check_val("sweep_cm", {28'h0, cnt_mispredicts}, exp_m);
      lookup("post_140", 32'h140, 1'b0, 32'h0, 32'h144);
      lookup("post_104", 32'h104, 1'b0, 32'h0, 32'h108);
      lookup("post_10c", 32'h10C, 1'b0, 32'h0, 32'h110);
      lookup("post_drop", 32'h110, 1'b0, 32'h0, 32'h114);
      step();
      check_val("no_extend", {31'h0, busy}, 32'h0);

      // Statistics saturate at 4'hF.
      for (int i = 0; i < 20; i++)
         resolve("many", 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0, 1'b0, 32'h604);
      check_val("cnt_sat", {28'h0, cnt_branches}, 32'hF);

      // Reset in the middle of a sweep.
      resolve("pre_rst", 1'b1, 1'b0, 1'b1, 32'h104, 32'h700, 1'b1, 32'h700, 1'b0, 32'h700);
      inv_req = 1'b1;
      step();
      inv_req = 1'b0;
      step();
      step();
      check_val("mid_busy", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      check_val("arst_busy", {31'h0, busy}, 32'h0);
      check_val("arst_cb", {28'h0, cnt_branches}, 32'h0);
      check_val("arst_cm", {28'h0, cnt_mispredicts}, 32'h0);
      lookup("arst_look", 32'h104, 1'b0, 32'h0, 32'h108);
      step();
      rst = 1'b0;
      step();
      check_val("post_rst_busy", {31'h0, busy}, 32'h0);
      lookup("post_rst_look", 32'h104, 1'b0, 32'h0, 32'h108);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
